// File: rtl/dsp_zmux_pipe_if.sv
// Operand/result bundle for the DSP post-adder Z-operand multiplexer.
// The master drives OPMODE, enables and operands; the slave returns the selected Z operand and status.
interface dsp_zmux_pipe_if #(
  parameter int WIDTH = 48
);
  logic [6:0]       opmode;
  logic             ce_opmode;
  logic             ce_c;
  logic             ce_z;
  logic [WIDTH-1:0] pcin;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic             in_valid;
  logic             err_clr;
  logic [WIDTH-1:0] z_out;
  logic             out_valid;
  logic             invalid;
  logic             err_sticky;

  modport master (
    output opmode, ce_opmode, ce_c, ce_z, pcin, p, c, in_valid, err_clr,
    input  z_out, out_valid, invalid, err_sticky
  );

  modport slave (
    input  opmode, ce_opmode, ce_c, ce_z, pcin, p, c, in_valid, err_clr,
    output z_out, out_valid, invalid, err_sticky
  );
endinterface

// File: rtl/dsp_zmux_pipe.sv
// Pipelined Z-operand select for the DSP post-adder: zero/PCIN/P/C/shifted operands,
// optional OPMODE, C and Z registers with clock enables, valid tracking and illegal-OPMODE flagging.
module dsp_zmux_pipe #(
  parameter int WIDTH     = 48,
  parameter int SHIFT     = 17,
  parameter int OPMODEREG = 1,
  parameter int CREG      = 1,
  parameter int ZREG      = 1
) (
  input logic             clk,
  input logic             rst,
  dsp_zmux_pipe_if.slave  zif
);

  logic [6:0]              opm;
  logic                    vld_p0;
  logic signed [WIDTH-1:0] c_e;
  logic signed [WIDTH-1:0] z_p1_d;
  logic                    inv_p1_d;
  logic signed [WIDTH-1:0] z_o;
  logic                    inv_o;
  logic                    vld_o;
  logic                    err_q;
  logic                    unused_ce;

  // Enables feeding a bypassed register have no effect in that configuration.
  assign unused_ce = zif.ce_opmode ^ zif.ce_c ^ zif.ce_z;

  function automatic logic signed [WIDTH-1:0] asr(input logic signed [WIDTH-1:0] x);
    return x >>> SHIFT;
  endfunction

  // ---- p0: OPMODE / valid and C input stage ----
  generate
    if (OPMODEREG != 0) begin : g_opm_reg
      logic [6:0] opm_p0_q;
      logic       vld_p0_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          opm_p0_q <= '0;
          vld_p0_q <= 1'b0;
        end else if (zif.ce_opmode) begin
          opm_p0_q <= zif.opmode;
          vld_p0_q <= zif.in_valid;
        end
      end
      assign opm    = opm_p0_q;
      assign vld_p0 = vld_p0_q;
    end else begin : g_opm_byp
      assign opm    = zif.opmode;
      assign vld_p0 = zif.in_valid;
    end

    if (CREG != 0) begin : g_c_reg
      logic signed [WIDTH-1:0] c_p0_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          c_p0_q <= '0;
        end else if (zif.ce_c) begin
          c_p0_q <= $signed(zif.c);
        end
      end
      assign c_e = c_p0_q;
    end else begin : g_c_byp
      assign c_e = $signed(zif.c);
    end
  endgenerate

  always_comb begin
    z_p1_d   = '0;
    inv_p1_d = 1'b0;
    case (opm[6:4])
      3'b000: z_p1_d = '0;
      3'b001: z_p1_d = $signed(zif.pcin);
      3'b010: z_p1_d = $signed(zif.p);
      3'b011: z_p1_d = c_e;
      3'b100: begin
        if (opm[3:0] == 4'b1000) z_p1_d = $signed(zif.p);
        else                     inv_p1_d = 1'b1;
      end
      3'b101: z_p1_d = asr($signed(zif.pcin));
      3'b110: z_p1_d = asr($signed(zif.p));
      default: inv_p1_d = 1'b1;
    endcase
  end

  // ---- p1: Z output stage ----
  generate
    if (ZREG != 0) begin : g_z_reg
      logic signed [WIDTH-1:0] z_p1_q;
      logic                    inv_p1_q;
      logic                    vld_p1_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          z_p1_q   <= '0;
          inv_p1_q <= 1'b0;
          vld_p1_q <= 1'b0;
        end else if (zif.ce_z) begin
          z_p1_q   <= z_p1_d;
          inv_p1_q <= inv_p1_d;
          vld_p1_q <= vld_p0;
        end
      end
      assign z_o   = z_p1_q;
      assign inv_o = inv_p1_q;
      assign vld_o = vld_p1_q;
    end else begin : g_z_byp
      assign z_o   = z_p1_d;
      assign inv_o = inv_p1_d;
      assign vld_o = vld_p0;
    end
  endgenerate

  // Setting takes priority over a simultaneous clear so no illegal result is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (inv_o && vld_o) begin
      err_q <= 1'b1;
    end else if (zif.err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign zif.z_out      = z_o;
  assign zif.invalid    = inv_o;
  assign zif.out_valid  = vld_o;
  assign zif.err_sticky = err_q;

endmodule

// File: tb/tb_dsp_zmux_pipe.sv
// Randomized and directed bench for dsp_zmux_pipe: default-parameter pipelined instance
// plus a fully combinational 24-bit instance, both checked against a behavioural model.
module tb_dsp_zmux_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dsp_zmux_pipe_if #(.WIDTH(48)) if0 ();
  dsp_zmux_pipe_if #(.WIDTH(24)) if1 ();

  dsp_zmux_pipe dut0 (.clk(clk), .rst(rst), .zif(if0));

  dsp_zmux_pipe #(
    .WIDTH(24), .SHIFT(8), .OPMODEREG(0), .CREG(0), .ZREG(0)
  ) dut1 (.clk(clk), .rst(rst), .zif(if1));

  // Model state for the default instance (what each register should hold).
  logic [6:0]  m_opm = '0;
  logic [47:0] m_c   = '0;
  logic [47:0] m_z   = '0;
  bit          m_v1  = 0;
  bit          m_v2  = 0;
  bit          m_inv = 0;
  bit          m_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] asr_ref(input logic [63:0] x, input int w, input int s);
    logic [63:0] m;
    logic [63:0] r;
    m = (64'd1 << w) - 64'd1;
    r = (x & m) >> s;
    if (x[w-1]) r = r | (m & ~(m >> s));
    return r;
  endfunction

  function automatic logic [63:0] ref_sel(input logic [6:0] o, input logic [63:0] pc,
                                          input logic [63:0] pp, input logic [63:0] cc,
                                          input int w, input int s, output bit ill);
    logic [63:0] r;
    r   = 64'd0;
    ill = 0;
    case (o[6:4])
      3'd1: r = pc;
      3'd2: r = pp;
      3'd3: r = cc;
      3'd4: if (o[3:0] == 4'b1000) r = pp; else ill = 1;
      3'd5: r = asr_ref(pc, w, s);
      3'd6: r = asr_ref(pp, w, s);
      3'd7: ill = 1;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic step();
    logic [63:0] zc;
    bit          ic;
    bit          set;
    @(posedge clk);
    zc  = ref_sel(m_opm, {16'd0, if0.pcin}, {16'd0, if0.p}, {16'd0, m_c}, 48, 17, ic);
    set = m_inv && m_v2;
    if (rst) begin
      m_opm = '0; m_c = '0; m_z = '0;
      m_v1 = 0; m_v2 = 0; m_inv = 0; m_err = 0;
    end else begin
      if (if0.ce_z) begin
        m_z   = zc[47:0];
        m_inv = ic;
        m_v2  = m_v1;
      end
      if (if0.ce_opmode) begin
        m_opm = if0.opmode;
        m_v1  = if0.in_valid;
      end
      if (if0.ce_c) m_c = if0.c;
      if (set)              m_err = 1;
      else if (if0.err_clr) m_err = 0;
    end
    #1;
    chk("z_out",      {16'd0, if0.z_out},    {16'd0, m_z});
    chk("out_valid",  {63'd0, if0.out_valid}, {63'd0, m_v2});
    chk("invalid",    {63'd0, if0.invalid},   {63'd0, m_inv});
    chk("err_sticky", {63'd0, if0.err_sticky}, {63'd0, m_err});
  endtask

  task automatic cyc(input logic [6:0] opm, input logic [47:0] pc, input logic [47:0] pp,
                     input logic [47:0] cc, input bit vld, input bit clr, input bit cez);
    if0.opmode    = opm;
    if0.pcin      = pc;
    if0.p         = pp;
    if0.c         = cc;
    if0.in_valid  = vld;
    if0.err_clr   = clr;
    if0.ce_opmode = 1'b1;
    if0.ce_c      = 1'b1;
    if0.ce_z      = cez;
    step();
  endtask

  initial begin
    logic [63:0] t;
    logic [63:0] u;
    logic [63:0] exp1;
    bit          ill1;

    if0.opmode = 7'b0110000; if0.ce_opmode = 1'b1; if0.ce_c = 1'b1; if0.ce_z = 1'b1;
    if0.pcin = '0; if0.p = '0; if0.c = 48'h123456789ABC; if0.in_valid = 1'b1; if0.err_clr = 1'b0;
    if1.opmode = '0; if1.ce_opmode = 1'b1; if1.ce_c = 1'b1; if1.ce_z = 1'b1;
    if1.pcin = '0; if1.p = '0; if1.c = '0; if1.in_valid = 1'b0; if1.err_clr = 1'b0;

    // Reset with C selected, then release.
    rst = 1'b1;
    cyc(7'b0110000, 48'd0, 48'd0, 48'h123456789ABC, 1, 0, 1);
    cyc(7'b0110000, 48'd0, 48'd0, 48'h123456789ABC, 1, 0, 1);
    chk("rst_z", {16'd0, if0.z_out}, 64'd0);
    chk("rst_vld", {63'd0, if0.out_valid}, 64'd0);
    rst = 1'b0;
    cyc(7'b0110000, 48'd0, 48'd0, 48'h123456789ABC, 1, 0, 1);
    chk("lat1_vld", {63'd0, if0.out_valid}, 64'd0);
    cyc(7'b0110000, 48'd0, 48'd0, 48'h123456789ABC, 1, 0, 1);
    chk("c_after_rst", {16'd0, if0.z_out}, 64'h123456789ABC);
    chk("lat2_vld", {63'd0, if0.out_valid}, 64'd1);

    // Shift modes.
    cyc(7'b1010000, 48'h800000000000, 48'd0, 48'd0, 1, 0, 1);
    cyc(7'b1010000, 48'h800000000000, 48'd0, 48'd0, 1, 0, 1);
    chk("pcin_asr", {16'd0, if0.z_out}, 64'hFFFFC0000000);
    cyc(7'b1100000, 48'd0, 48'h000000020000, 48'd0, 1, 0, 1);
    cyc(7'b1100000, 48'd0, 48'h000000020000, 48'd0, 1, 0, 1);
    chk("p_asr", {16'd0, if0.z_out}, 64'd1);

    // Code 100 qualification.
    cyc(7'b1001000, 48'd0, 48'hA5, 48'd0, 1, 0, 1);
    cyc(7'b1001000, 48'd0, 48'hA5, 48'd0, 1, 0, 1);
    chk("c100_ok_z", {16'd0, if0.z_out}, 64'hA5);
    chk("c100_ok_inv", {63'd0, if0.invalid}, 64'd0);
    cyc(7'b1000101, 48'd0, 48'hA5, 48'd0, 1, 0, 1);
    cyc(7'b1000101, 48'd0, 48'hA5, 48'd0, 1, 0, 1);
    chk("c100_bad_z", {16'd0, if0.z_out}, 64'd0);
    chk("c100_bad_inv", {63'd0, if0.invalid}, 64'd1);
    chk("c100_err_lag", {63'd0, if0.err_sticky}, 64'd0);
    cyc(7'b0000000, 48'd0, 48'hA5, 48'd0, 1, 0, 1);
    chk("c100_err", {63'd0, if0.err_sticky}, 64'd1);

    // Sticky error: clear racing a set, then a lone clear.
    cyc(7'b1110000, 48'd0, 48'd0, 48'd0, 1, 0, 1);
    cyc(7'b1110000, 48'd0, 48'd0, 48'd0, 1, 1, 1);
    cyc(7'b0100000, 48'd0, 48'd0, 48'd0, 1, 1, 1);
    chk("clr_vs_set", {63'd0, if0.err_sticky}, 64'd1);
    cyc(7'b0100000, 48'd0, 48'd0, 48'd0, 1, 0, 1);
    cyc(7'b0100000, 48'd0, 48'd0, 48'd0, 1, 1, 1);
    chk("clr_alone", {63'd0, if0.err_sticky}, 64'd0);

    // Z stall while P changes.
    cyc(7'b0100000, 48'd0, 48'd1, 48'd0, 1, 0, 1);
    cyc(7'b0100000, 48'd0, 48'd1, 48'd0, 1, 0, 1);
    cyc(7'b0100000, 48'd0, 48'd2, 48'd0, 0, 0, 0);
    cyc(7'b0100000, 48'd0, 48'd3, 48'd0, 0, 0, 0);
    cyc(7'b0100000, 48'd0, 48'd3, 48'd0, 0, 0, 0);
    chk("stall_z", {16'd0, if0.z_out}, 64'd1);
    chk("stall_vld", {63'd0, if0.out_valid}, 64'd1);
    cyc(7'b0100000, 48'd0, 48'd3, 48'd0, 0, 0, 1);
    chk("release_z", {16'd0, if0.z_out}, 64'd3);

    // Randomized traffic with occasional resets, clears and stalls.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      t = {$urandom, $urandom};
      u = {$urandom, $urandom};
      if0.opmode    = 7'($urandom);
      if0.pcin      = t[47:0];
      if0.p         = u[47:0];
      t = {$urandom, $urandom};
      if0.c         = t[47:0];
      if0.in_valid  = 1'($urandom);
      if0.err_clr   = ($urandom_range(0, 7) == 0);
      if0.ce_opmode = ($urandom_range(0, 4) != 0);
      if0.ce_c      = ($urandom_range(0, 4) != 0);
      if0.ce_z      = ($urandom_range(0, 4) != 0);
      step();
    end
    rst = 1'b0;

    // Combinational 24-bit instance.
    if1.opmode = 7'b1010000; if1.pcin = 24'h800000; if1.in_valid = 1'b1;
    #1;
    chk("w24_asr", {40'd0, if1.z_out}, 64'hFF8000);
    chk("w24_vld", {63'd0, if1.out_valid}, 64'd1);
    for (int i = 0; i < 60; i++) begin
      t = {$urandom, $urandom};
      if1.opmode   = 7'($urandom);
      if1.pcin     = t[23:0];
      if1.p        = t[47:24];
      u = {$urandom, $urandom};
      if1.c        = u[23:0];
      if1.in_valid = 1'($urandom);
      #1;
      exp1 = ref_sel(if1.opmode, {40'd0, if1.pcin}, {40'd0, if1.p}, {40'd0, if1.c}, 24, 8, ill1);
      chk("w24_z", {40'd0, if1.z_out}, exp1);
      chk("w24_inv", {63'd0, if1.invalid}, {63'd0, ill1});
      chk("w24_v", {63'd0, if1.out_valid}, {63'd0, if1.in_valid});
      #3;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_zmux_pipe.md
# dsp_zmux_pipe

Parametrised, pipelined Z-operand multiplexer for the DSP slice post-adder. It selects the Z operand from zero, PCIN, P, C, or 17-bit arithmetic-shifted PCIN/P, according to the 7-bit OPMODE. It adds optional OPMODE, C and Z pipeline registers with independent clock enables, a valid pipeline, and invalid-OPMODE detection. It feeds the ALU Z port and replaces the purely combinational Z select.

## Interface

**Parameters**

- `WIDTH`, 48: datapath width of all data ports.
- `SHIFT`, 17: right-shift amount for the shifted modes. Legal range is 1..`WIDTH`-1.
- `OPMODEREG`, 1: OPMODE input register present (1) or bypassed (0).
- `CREG`, 1: C input register present (1) or bypassed (0).
- `ZREG`, 1: Z output register present (1) or bypassed (0).

**Ports**

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `opmode`, input, 7: OPMODE; `[6:4]` is the Z select, `[3:0]` qualifies code 100.
- `ce_opmode`, input, 1: OPMODE register enable.
- `ce_c`, input, 1: C register enable.
- `ce_z`, input, 1: Z register enable; also advances the valid/invalid output stage.
- `pcin`, input, `WIDTH`: cascade input.
- `p`, input, `WIDTH`: slice P feedback.
- `c`, input, `WIDTH`: C operand.
- `in_valid`, input, 1: qualifies the current operands.
- `err_clr`, input, 1: clears `err_sticky`.
- `z_out`, output, `WIDTH`: selected Z operand.
- `out_valid`, output, 1: `z_out` carries a qualified result.
- `invalid`, output, 1: `z_out` was produced under an illegal OPMODE.
- `err_sticky`, output, 1: an illegal OPMODE has been seen since the last reset/clear.

## Operation

- Effective OPMODE (`opm`): the OPMODE register output if `OPMODEREG`=1, else `opmode` directly. Same rule for effective C (`c_e`) with `CREG`.
- Selection on `opm[6:4]`:
  - 000 -> 0.
  - 001 -> `pcin`.
  - 010 -> `p`.
  - 011 -> `c_e`.
  - 100 -> `p`, only when `opm[3:0]`=1000; otherwise 0 and illegal.
  - 101 -> `pcin` >>> `SHIFT`, arithmetic (sign bit `pcin[WIDTH-1]` replicated into the top `SHIFT` bits).
  - 110 -> `p` >>> `SHIFT`, arithmetic.
  - 111 -> 0 and illegal.
- Illegal OPMODE:
  - `z_out` is forced to 0.
  - `invalid`=1 in the same stage as the corresponding `z_out`.
  - `err_sticky` sets when `invalid`=1 and `out_valid`=1 are presented at the output.
- `err_sticky` update:
  - If the set condition and `err_clr` occur in the same cycle, set wins and `err_sticky` stays 1.
  - `err_clr` alone clears it on the next edge.
- `pcin` and `p` are never registered inside this block.
- Valid pipeline: `in_valid` is delayed to match the OPMODE path.
  - Delay `OPMODEREG` (gated by `ce_opmode`), then `ZREG` (gated by `ce_z`).
  - `out_valid` tracks the delayed value.
- Register enables: each register holds its value when its CE is 0. Stalling `ce_z` freezes `z_out`, `invalid` and `out_valid`.
- Reset:
  - Every register clears to 0: OPMODE register (selects zero), C register, Z register, valid/invalid stages, `err_sticky`.
  - Reset overrides all CEs and `err_clr`.
  - Reset mid-stream discards in-flight data; first qualified output appears a full latency after the first post-reset `in_valid`.

## Timing

- Reset values: `z_out`=0, `out_valid`=0, `invalid`=0, `err_sticky`=0 (when `ZREG`=0, these reflect the combinational function of the reset register contents, all 0).
- Latency with CEs held high:
  - `opmode`/`in_valid` -> outputs: `OPMODEREG`+`ZREG` cycles.
  - `c` -> `z_out`: `CREG`+`ZREG` cycles.
  - `pcin`/`p` -> `z_out`: `ZREG` cycles.
- Default parameters: OPMODE change at edge N takes effect on `z_out` after edge N+2; C after edge N+2; P after edge N+1.
- OPMODE change while `ce_opmode`=0 is ignored until `ce_opmode` returns to 1.
- Throughput: one result per cycle; no backpressure.
- `err_sticky` rises one cycle after the illegal `invalid`/`out_valid` pair is presented.

## Test plan

- Reset with `opmode`=0110000, `c`=0x123456789ABC, all CEs=1: outputs 0 during reset; `z_out`=0x123456789ABC two cycles after release; `out_valid` follows `in_valid` with latency 2.
- Shift modes, `pcin`=0x800000000000, `opmode`=1010000: `z_out`=0xFFFFC0000000. Then `p`=0x000000020000, `opmode`=1100000: `z_out`=0x000000000001.
- Code 100 qualification, `p`=0xA5: `opmode`=1001000 gives `z_out`=0xA5, `invalid`=0; `opmode`=1000101 gives `z_out`=0, `invalid`=1, `err_sticky`=1 next cycle.
- Sticky error: `opmode`=1110000 with `in_valid`=1 sets `err_sticky`. `err_clr` in the same cycle as a new illegal result leaves it 1; `err_clr` alone clears it next edge.
- CE stall: `ce_z`=0 for 3 cycles while `p` changes 1->2->3; `z_out`, `out_valid` and `invalid` hold. Releasing `ce_z` shows the current selection one edge later.
- Parameter sweep `OPMODEREG`/`CREG`/`ZREG` = 0/0/0 and 1/1/1, `WIDTH`=24, `SHIFT`=8: latency 0 (combinational) vs 2; `pcin`=0x800000 shifted gives 0xFF8000.
